// File: rtl/vram_arbiter.sv
// Single-port text/attribute VRAM arbiter: video fetch has priority, CPU is
// protected from starvation by a counter and a one-entry video holding slot.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   vid_req, vid_addr             single-cycle video read strobe + address
//   vid_rdata, vid_valid          video read data, valid while vid_valid=1
//   vid_overrun                   sticky flag: a video request was dropped
//   cpu_req, cpu_we, cpu_addr,
//   cpu_wdata                     CPU request, held stable until cpu_ack
//   cpu_rdata, cpu_ack            CPU read data, one-cycle completion pulse
//   mem_addr, mem_we, mem_wdata   registered RAM controls
//   mem_rdata                     RAM data, one cycle after the address
module vram_arbiter #(
    parameter int AW           = 12,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_valid,
    output logic          vid_overrun,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_WAIT  = 2'd1;
    localparam logic [1:0] C_ISSUE = 2'd2;
    localparam logic [1:0] C_DATA  = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]    state;
    logic [3:0]    starve;
    logic          hold_v;
    logic [AW-1:0] hold_addr;
    logic          vid_p1;
    logic [DW-1:0] rdata_q;

    logic cpu_pend;
    logic grant_hold;
    logic grant_cpu;
    logic grant_vid;
    logic defer_vid;
    logic drop_vid;

    assign cpu_pend  = (state == C_WAIT);
    assign vid_rdata = mem_rdata;
    // RAM data arrives in the ack cycle itself; the register keeps the
    // last read value visible once the ack pulse has gone.
    assign cpu_rdata = cpu_ack ? mem_rdata : rdata_q;

    always_comb begin
        grant_hold = 1'b0;
        grant_cpu  = 1'b0;
        grant_vid  = 1'b0;
        defer_vid  = 1'b0;
        drop_vid   = 1'b0;
        if (hold_v) begin
            // Slot drains this cycle but cannot accept a new entry too.
            grant_hold = 1'b1;
            drop_vid   = vid_req;
        end else if (cpu_pend && starve == LIMIT) begin
            grant_cpu = 1'b1;
            defer_vid = vid_req;
        end else if (vid_req) begin
            grant_vid = 1'b1;
        end else if (cpu_pend) begin
            grant_cpu = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            hold_v      <= 1'b0;
            hold_addr   <= '0;
            vid_p1      <= 1'b0;
            vid_valid   <= 1'b0;
            vid_overrun <= 1'b0;
            starve      <= '0;
            state       <= C_IDLE;
            cpu_ack     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            mem_we <= 1'b0;
            if (grant_hold) begin
                mem_addr <= hold_addr;
            end else if (grant_vid) begin
                mem_addr <= vid_addr;
            end else if (grant_cpu) begin
                mem_addr  <= cpu_addr;
                mem_we    <= cpu_we;
                mem_wdata <= cpu_wdata;
            end

            if (grant_hold) begin
                hold_v <= 1'b0;
            end else if (defer_vid) begin
                hold_v    <= 1'b1;
                hold_addr <= vid_addr;
            end

            if (drop_vid) begin
                vid_overrun <= 1'b1;
            end

            vid_p1    <= grant_hold | grant_vid;
            vid_valid <= vid_p1;

            if (grant_cpu) begin
                starve <= '0;
            end else if (cpu_pend && starve < LIMIT) begin
                starve <= starve + 4'd1;
            end

            cpu_ack <= (state == C_ISSUE);
            if (cpu_ack) begin
                rdata_q <= mem_rdata;
            end

            unique case (state)
                C_IDLE:  if (cpu_req) state <= C_WAIT;
                C_WAIT:  if (grant_cpu) state <= C_ISSUE;
                C_ISSUE: state <= C_DATA;
                C_DATA:  state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: per-cycle vector table plus sequences
// for starvation/deferral, reset abort and VGA-cadence traffic.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [11:0] vid_addr = '0;
    logic [7:0]  vid_rdata;
    logic        vid_valid;
    logic        vid_overrun;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0] ram [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.AW(12), .DW(8), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_rdata(vid_rdata), .vid_valid(vid_valid),
        .vid_overrun(vid_overrun),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous read-first RAM
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        vr;
        logic [11:0] va;
        logic        cr;
        logic        cw;
        logic [11:0] ca;
        logic [7:0]  cd;
        logic [11:0] ma;
        logic        we;
        logic        vv;
        logic [7:0]  vd;
        logic        ack;
        logic        ckd;
        logic [7:0]  rd;
    } vec_t;

    vec_t vec [20];

    initial begin
        int acks;
        int n;
        bit ack_seen;
        bit out_v;
        int req_cyc;
        logic [7:0] exp_d;

        for (int i = 0; i < 4096; i++) ram[i] = 8'((i * 7 + 3) & 255);
        ram[12'h0A0] = 8'h41;

        //          vr    va       cr    cw    ca       cd     ma       we    vv    vd     ack   ckd   rd
        vec[0]  = '{1'b1, 12'h0A0, 1'b0, 1'b0, 12'h000, 8'h00, 12'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[1]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h0A0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[2]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h0A0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00};
        vec[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h0A0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[4]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h7CF, 8'h1F, 12'h0A0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[5]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h7CF, 8'h1F, 12'h0A0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[6]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h7CF, 8'h1F, 12'h7CF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[7]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h7CF, 8'h1F, 12'h7CF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vec[8]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h7CF, 8'h00, 12'h7CF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[9]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h7CF, 8'h00, 12'h7CF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[10] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h7CF, 8'h00, 12'h7CF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[11] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h7CF, 8'h00, 12'h7CF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h1F};
        vec[12] = '{1'b1, 12'h7CF, 1'b0, 1'b0, 12'h000, 8'h00, 12'h7CF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[13] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h7CF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[14] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h7CF, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 8'h00};
        vec[15] = '{1'b1, 12'h105, 1'b1, 1'b0, 12'h2AB, 8'h00, 12'h7CF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[16] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h2AB, 8'h00, 12'h105, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vec[17] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h2AB, 8'h00, 12'h2AB, 1'b0, 1'b1, 8'h26, 1'b0, 1'b0, 8'h00};
        vec[18] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h2AB, 8'h00, 12'h2AB, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB0};
        vec[19] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h2AB, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_vid_valid", 32'(vid_valid), 32'h0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("rst_overrun", 32'(vid_overrun), 32'h0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        rst_n = 1'b1;

        // Per-cycle vector table
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            vid_req   = vec[i].vr;
            vid_addr  = vec[i].va;
            cpu_req   = vec[i].cr;
            cpu_we    = vec[i].cw;
            cpu_addr  = vec[i].ca;
            cpu_wdata = vec[i].cd;
            @(negedge clk);
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vec[i].ma));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vec[i].we));
            chk($sformatf("v%0d_vid_valid", i), 32'(vid_valid), 32'(vec[i].vv));
            chk($sformatf("v%0d_cpu_ack", i), 32'(cpu_ack), 32'(vec[i].ack));
            if (vec[i].vv)
                chk($sformatf("v%0d_vid_rdata", i), 32'(vid_rdata), 32'(vec[i].vd));
            if (vec[i].ckd)
                chk($sformatf("v%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(vec[i].rd));
        end

        // Contention: video every cycle against a pending CPU read
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            vid_req  = (k <= 6);
            vid_addr = 12'h300 + 12'(k);
            cpu_req  = (k <= 6);
            cpu_we   = 1'b0;
            cpu_addr = 12'h2AB;
            @(negedge clk);
            if (k == 4) begin
                chk("cont_u4_ack", 32'(cpu_ack), 32'h0);
                chk("cont_u4_addr", 32'(mem_addr), 32'h303);
            end
            if (k == 5) begin
                chk("cont_u5_addr", 32'(mem_addr), 32'h2AB);
                chk("cont_u5_we", 32'(mem_we), 32'h0);
                chk("cont_u5_ack", 32'(cpu_ack), 32'h0);
                chk("cont_u5_overrun", 32'(vid_overrun), 32'h0);
            end
            if (k == 6) begin
                chk("cont_u6_ack", 32'(cpu_ack), 32'h1);
                chk("cont_u6_rdata", 32'(cpu_rdata), 32'hB0);
                chk("cont_u6_addr", 32'(mem_addr), 32'h304);
                chk("cont_u6_vv", 32'(vid_valid), 32'h0);
                chk("cont_u6_overrun", 32'(vid_overrun), 32'h1);
            end
            if (k == 7) begin
                chk("cont_u7_vv", 32'(vid_valid), 32'h1);
                chk("cont_u7_vdata", 32'(vid_rdata), 32'h1F);
                chk("cont_u7_addr", 32'(mem_addr), 32'h306);
                chk("cont_u7_ack", 32'(cpu_ack), 32'h0);
            end
        end
        vid_req = 1'b0;
        repeat (3) @(posedge clk);

        // Reset in the middle of a CPU read
        #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 12'h123;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rstmid_issue_addr", 32'(mem_addr), 32'h123);
        #1;
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rstmid_mem_we", 32'(mem_we), 32'h0);
        chk("rstmid_mem_addr", 32'(mem_addr), 32'h0);
        chk("rstmid_overrun", 32'(vid_overrun), 32'h0);
        chk("rstmid_ack", 32'(cpu_ack), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack || vid_valid) acks++;
        end
        chk("rstmid_no_pulse", 32'(acks), 32'h0);

        // VGA cadence with continuous CPU write/read pairs
        acks     = 0;
        n        = 0;
        ack_seen = 1'b0;
        out_v    = 1'b0;
        req_cyc  = 0;
        exp_d    = 8'h5A;
        @(posedge clk);
        #1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 12'h400;
        cpu_wdata = 8'h5A;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(posedge clk);
            #1;
            vid_req  = (cyc % 4 == 0) && (cyc < 996);
            vid_addr = 12'h0A0;
            if (vid_req) begin
                if (out_v) chk("cad_vid_lost", 32'h1, 32'h0);
                out_v   = 1'b1;
                req_cyc = cyc;
            end
            if (ack_seen) begin
                n++;
                ack_seen  = 1'b0;
                exp_d     = 8'(n / 2) ^ 8'h5A;
                cpu_we    = (n % 2 == 0);
                cpu_addr  = 12'h400 + 12'((n / 2) % 256);
                cpu_wdata = exp_d;
            end
            @(negedge clk);
            if (vid_valid) begin
                chk("cad_vid_latency", 32'(out_v && (cyc - req_cyc) <= 3), 32'h1);
                chk("cad_vid_data", 32'(vid_rdata), 32'h41);
                out_v = 1'b0;
            end
            if (cpu_ack) begin
                acks++;
                ack_seen = 1'b1;
                if (n % 2 == 1) chk("cad_cpu_rdata", 32'(cpu_rdata), 32'(exp_d));
            end
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        chk("cad_vid_drained", 32'(out_v), 32'h0);
        chk("cad_cpu_rate", 32'(acks >= 125), 32'h1);
        chk("cad_overrun", 32'(vid_overrun), 32'h0);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
